// File: rtl/sevenseg_mux_driver.sv
// Multiplexed N-digit seven-segment driver with double-buffered display data,
// per-digit decimal points, leading-zero blanking and PWM brightness.
module sevenseg_mux_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BRIGHT_WIDTH = 4
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic                      LOAD,
    input  logic [4*NUM_DIGITS-1:0]   DIGITS_IN,
    input  logic [NUM_DIGITS-1:0]     DOTS_IN,
    input  logic                      BLANK_LZ,
    input  logic [BRIGHT_WIDTH-1:0]   BRIGHTNESS,
    output logic [7:0]                HEX_OUT,
    output logic [NUM_DIGITS-1:0]     SEG_SELECT,
    output logic                      FRAME_DONE,
    output logic                      UPDATED
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]             r_presc;
    logic [IW-1:0]             r_idx;
    logic [BRIGHT_WIDTH-1:0]   r_pwm;
    logic [4*NUM_DIGITS-1:0]   r_act_dig;
    logic [NUM_DIGITS-1:0]     r_act_dot;
    logic [4*NUM_DIGITS-1:0]   r_sh_dig;
    logic [NUM_DIGITS-1:0]     r_sh_dot;
    logic                      r_pending;
    logic [7:0]                r_hex;
    logic [NUM_DIGITS-1:0]     r_sel;
    logic                      r_frame_done;
    logic                      r_updated;

    logic                      w_slot_end;
    logic                      w_boundary;
    logic                      w_lit;
    logic [3:0]                w_nib;
    logic                      w_dot;
    logic [NUM_DIGITS-1:0]     w_blank;
    logic                      w_upper_zero;
    logic [NUM_DIGITS-1:0]     w_sel;

    // Active-low gfedcba pattern for one hex nibble.
    function automatic logic [6:0] f_seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    assign w_slot_end = (r_presc == PRESC_MAX);
    assign w_boundary = w_slot_end && (r_idx == IDX_MAX);
    assign w_lit      = (r_pwm <= BRIGHTNESS);
    assign w_nib      = r_act_dig[{r_idx, 2'b00} +: 4];
    assign w_dot      = r_act_dot[r_idx];

    // A digit blanks when it and everything above it is zero with no dot lit.
    always_comb begin
        w_blank      = '0;
        w_upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_upper_zero = w_upper_zero & (r_act_dig[4*i +: 4] == 4'h0) & ~r_act_dot[i];
            w_blank[i]   = BLANK_LZ & w_upper_zero;
        end
    end

    // One-hot-low anode pattern for the digit currently being scanned.
    always_comb begin
        w_sel        = '1;
        w_sel[r_idx] = 1'b0;
    end

    // Slot prescaler, digit index and free-running PWM counter.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_presc <= '0;
            r_idx   <= '0;
            r_pwm   <= '0;
        end else begin
            r_pwm <= r_pwm + BRIGHT_WIDTH'(1'b1);
            if (w_slot_end) begin
                r_presc <= '0;
                if (r_idx == IDX_MAX) begin
                    r_idx <= '0;
                end else begin
                    r_idx <= r_idx + IW'(1'b1);
                end
            end else begin
                r_presc <= r_presc + PW'(1'b1);
            end
        end
    end

    // Shadow/active double buffer; a LOAD on the boundary bypasses the shadow.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_act_dig    <= '0;
            r_act_dot    <= '0;
            r_sh_dig     <= '0;
            r_sh_dot     <= '0;
            r_pending    <= 1'b0;
            r_frame_done <= 1'b0;
            r_updated    <= 1'b0;
        end else begin
            r_frame_done <= w_boundary;
            r_updated    <= w_boundary & (r_pending | LOAD);
            if (w_boundary) begin
                r_pending <= 1'b0;
                if (LOAD) begin
                    r_act_dig <= DIGITS_IN;
                    r_act_dot <= DOTS_IN;
                    r_sh_dig  <= DIGITS_IN;
                    r_sh_dot  <= DOTS_IN;
                end else if (r_pending) begin
                    r_act_dig <= r_sh_dig;
                    r_act_dot <= r_sh_dot;
                end
            end else if (LOAD) begin
                r_sh_dig  <= DIGITS_IN;
                r_sh_dot  <= DOTS_IN;
                r_pending <= 1'b1;
            end
        end
    end

    // Registered cathode/anode drive; dark PWM phases release every pin.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_hex <= 8'hFF;
            r_sel <= '1;
        end else if (!w_lit) begin
            r_hex <= 8'hFF;
            r_sel <= '1;
        end else begin
            r_sel <= w_sel;
            r_hex <= w_blank[r_idx] ? 8'hFF : {~w_dot, f_seg_decode(w_nib)};
        end
    end

    assign HEX_OUT    = r_hex;
    assign SEG_SELECT = r_sel;
    assign FRAME_DONE = r_frame_done;
    assign UPDATED    = r_updated;

endmodule

// File: doc/sevenseg_mux_driver.md
Name: sevenseg_mux_driver

Overview:
- Parametrised multiplexed seven-segment display driver, the successor to the fixed 4-digit wrapper.
- Supports N digits, per-digit decimal points, leading-zero blanking and PWM brightness.
- Display data is double-buffered: a LOAD is latched into shadow registers and applied only at a frame boundary, so a multi-digit value never tears.
- Sits between the mouse/status logic and the board anode/cathode pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (legal 1..8)
REFRESH_DIV, 100000, clock cycles per digit slot (legal >= 2)
BRIGHT_WIDTH, 4, width of brightness control and PWM counter (legal 1..8)

Ports:
CLK  in  1  system clock (100 MHz on board)
RESET_N  in  1  asynchronous active-low reset
LOAD  in  1  single-cycle strobe; captures DIGITS_IN/DOTS_IN into shadow
DIGITS_IN  in  4*NUM_DIGITS  hex nibble per digit; nibble i = digit i, digit 0 rightmost
DOTS_IN  in  NUM_DIGITS  decimal point per digit, 1 = lit
BLANK_LZ  in  1  1 = suppress leading zeros (live input, not buffered)
BRIGHTNESS  in  BRIGHT_WIDTH  duty control; all-ones = 100 %
HEX_OUT  out  8  active-low cathodes {dp,g,f,e,d,c,b,a}
SEG_SELECT  out  NUM_DIGITS  active-low anodes, one-hot-low when lit
FRAME_DONE  out  1  one-cycle pulse after each full scan
UPDATED  out  1  one-cycle pulse when shadow data became active

Behaviour:
- Reset (async assert, sync release):
  - prescaler=0, digit index=0, PWM counter=0.
  - Active and shadow registers = 0; pending flag = 0.
  - HEX_OUT=8'hFF, SEG_SELECT=all ones, FRAME_DONE=0, UPDATED=0.
  - Reset mid-frame aborts the frame; a pending load is discarded.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - slot_end = (prescaler == REFRESH_DIV-1).
  - On slot_end, index increments; from NUM_DIGITS-1 it wraps to 0.
- Frame boundary = slot_end AND index == NUM_DIGITS-1. On that edge:
  - index goes to 0.
  - If pending, or LOAD is high in the same cycle: active <= shadow (coincident LOAD data bypasses directly into active), pending clears, UPDATED pulses in the following cycle.
  - FRAME_DONE pulses in the following cycle.
- LOAD outside a boundary:
  - Shadow <= inputs, pending=1.
  - Repeated LOADs before the boundary: last one wins; only one UPDATED pulse.
- PWM:
  - Free-running BRIGHT_WIDTH-bit counter, +1 every clock.
  - Digit is lit when pwm_cnt <= BRIGHTNESS, i.e. duty = (BRIGHTNESS+1)/2^BRIGHT_WIDTH.
  - When unlit: SEG_SELECT all ones, HEX_OUT=8'hFF.
- Leading-zero blanking:
  - Digit i (i >= 1) is blanked when BLANK_LZ=1, active nibbles i..NUM_DIGITS-1 are all 0, and active dots i..NUM_DIGITS-1 are all 0.
  - Digit 0 is never blanked.
  - Blanked digit: anode still driven low, HEX_OUT=8'hFF.
- Decoder (gfedcba, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex)
  - HEX_OUT[7] = ~dot.
- Latency: HEX_OUT and SEG_SELECT are registered, reflecting index/active/PWM state of the previous cycle (1 cycle).
- SEG_SELECT bit i low only while index==i and lit. Never more than one bit low.

Test Plan:
- Params 4/4/2, reset held 3 cycles then released -> HEX_OUT=FF and SEG_SELECT=F throughout reset; first anode E (digit 0) appears 1 cycle after release with BRIGHTNESS=3.
- LOAD DIGITS_IN=16'h4321, DOTS_IN=0, BRIGHTNESS=3 -> no change until the boundary. Next frame scans HEX_OUT F9,A4,B0,99 with SEG_SELECT E,D,B,7; 4 cycles each; FRAME_DONE every 16 cycles; UPDATED exactly once.
- BLANK_LZ=1, DIGITS_IN=16'h0050, dots 0 -> digit3 blank (FF), digit2 blank (FF), digit1 92, digit0 C0. Then DOTS_IN=4'b0100 -> digit2 shows 40 (0 with dp lit), digit3 stays FF.
- Value 0000 with BLANK_LZ=1 -> only digit 0 shows C0.
- BRIGHTNESS=0, BRIGHT_WIDTH=2 -> in each 4-cycle PWM period, anode low for exactly 1 cycle, HEX_OUT=FF the other 3.
- LOAD 16'h1111 mid-frame, then 16'h2222 two cycles later, then LOAD 16'h3333 on the boundary cycle -> display jumps straight to 3333 at that boundary. Single UPDATED pulse; 1111 and 2222 never displayed. Assert RESET_N mid-frame with a pending LOAD -> outputs FF/F immediately; after release the display shows 0000.
